// File: rtl/game_pkg.sv
// Shared types for the button front end: per-button debounce state and key code width.
// Also holds the lowest-set-bit encoder used to pick which pending key is offered.
// No logic of its own; no latency, no backpressure.
package game_pkg;

    localparam int KEY_CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_W = 2'd1,
        HELD    = 2'd2,
        REL_W   = 2'd3
    } btn_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [7:0] vec);
        lowest_set = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) lowest_set = KEY_CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchroniser, tick-enabled debounce FSM, optional auto-repeat (BSR_REPEAT_EN).
// Latency: 2 clk sync, then DEB_TICKS ticks; press_evt is combinational in the deciding tick cycle.
// No backpressure: events are fire-and-forget pulses, the parent queues them.
module btn_debounce_fsm
    import game_pkg::*;
#(
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic btn_raw,
    output logic btn_held,
    output logic press_evt
);

    localparam int               CNT_W    = $clog2(DEB_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    if (DEB_TICKS < 1 || REPEAT_TICKS < 0) begin : g_param_chk
        $error("btn_debounce_fsm: bad parameters");
    end

    logic             sync1_q, sync2_q;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             deb_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_evt = 1'b0;
        if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        if (DEB_TICKS == 1) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            deb_evt = 1'b1;
                        end else begin
                            state_d = PRESS_W;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PRESS_W: begin
                    if (!sync2_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        deb_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    // A single-sample debounce has no release wait to sit in.
                    if (!sync2_q) begin
                        if (DEB_TICKS == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = REL_W;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                REL_W: begin
                    if (sync2_q) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign btn_held = (state_q == HELD) || (state_q == REL_W);

`ifdef BSR_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_TICKS + 2);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_evt;

    // Counts only ticks spent entirely in HELD; any exit or (re)entry restarts it.
    always_comb begin
        rep_d   = rep_q;
        rep_evt = 1'b0;
        if (state_q != HELD || state_d != HELD) begin
            rep_d = '0;
        end else if (sample_tick && REPEAT_TICKS != 0) begin
            if (rep_q == REP_LAST) begin
                rep_d   = '0;
                rep_evt = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rep_q <= '0;
        else      rep_q <= rep_d;
    end

    assign press_evt = deb_evt | rep_evt;
`else
    assign press_evt = deb_evt;
`endif

endmodule

// File: rtl/button_sample_reader.sv
// Debounces N_BTN buttons on sample_tick and queues presses as key events (BSR_REPEAT_EN adds auto-repeat).
// Latency: key_valid rises 1 clk after the pending bit is set; one idle clk between accepts.
// Backpressure: key_ready low holds events pending; a repeat press of a pending key sets sticky ovf.
module button_sample_reader
    import game_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic [N_BTN-1:0]      btn_raw,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    input  logic                  key_ready,
    output logic [N_BTN-1:0]      btn_held,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    if (N_BTN < 1 || N_BTN > 8 || DEB_TICKS < 1 || REPEAT_TICKS < 0) begin : g_param_chk
        $error("button_sample_reader: bad parameters");
    end

    logic [N_BTN-1:0]      press_evt;
    logic [N_BTN-1:0]      pending_q, pending_d;
    logic [N_BTN-1:0]      clr_mask;
    logic                  key_valid_q, key_valid_d;
    logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
    logic                  ovf_q, ovf_d;
    logic                  accept;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce_fsm #(
            .DEB_TICKS    (DEB_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_deb (
            .clk         (clk),
            .rst         (rst),
            .sample_tick (sample_tick),
            .btn_raw     (btn_raw[g]),
            .btn_held    (btn_held[g]),
            .press_evt   (press_evt[g])
        );
    end

    always_comb begin
        accept   = key_valid_q && key_ready;
        clr_mask = '0;
        if (accept) clr_mask = N_BTN'(1) << key_code_q;
        // A press landing on the key being accepted re-arms it rather than overflowing.
        pending_d   = (pending_q & ~clr_mask) | press_evt;
        ovf_d       = (|(press_evt & pending_q & ~clr_mask)) | (ovf_q & ~ovf_clr);
        key_valid_d = (|pending_q) & ~accept;
        key_code_d  = lowest_set(8'(pending_q & ~clr_mask));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_button_sample_reader.sv
// Directed scenarios followed by a randomized run checked against a tick-level behavioural model.
module tb_button_sample_reader;
    localparam int TB_DEB = 4;
    localparam int TB_REP = 5;
`ifdef BSR_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_tick;
    logic [3:0] btn_raw;
    logic       key_valid;
    logic [2:0] key_code;
    logic       key_ready;
    logic [3:0] btn_held;
    logic       ovf;
    logic       ovf_clr;

    button_sample_reader #(
        .N_BTN        (4),
        .DEB_TICKS    (TB_DEB),
        .REPEAT_TICKS (TB_REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .btn_raw     (btn_raw),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .btn_held    (btn_held),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] acc_q[$];
    int         acc_cnt = 0;

    always @(negedge clk) begin
        if (rst === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
            acc_q.push_back(key_code);
            acc_cnt = acc_cnt + 1;
        end
    end

    // Model: a button's level flips after TB_DEB consecutive samples disagreeing with it.
    logic [3:0] m_lvl = '0;
    int         m_run[4];
    int         m_rep[4];
    int         exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        clk_n(1);
        sample_tick = 1'b1;
        clk_n(1);
        sample_tick = 1'b0;
    endtask

    task automatic hold_ticks(input logic [3:0] raw, input int n);
        btn_raw = raw;
        clk_n(1);
        repeat (n) tick();
    endtask

    task automatic model_tick(input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s[i] != m_lvl[i]) begin
                if (m_lvl[i]) m_rep[i] = 0;
                m_run[i]++;
                if (m_run[i] == TB_DEB) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                    m_rep[i] = 0;
                    if (s[i]) exp_q.push_back(i);
                end
            end else if (m_run[i] != 0) begin
                m_run[i] = 0;
            end else if (m_lvl[i] && REP_ON) begin
                m_rep[i]++;
                if (m_rep[i] == TB_REP) begin
                    m_rep[i] = 0;
                    exp_q.push_back(i);
                end
            end
        end
    endtask

    initial begin
        int         base;
        int         acc_rd;
        int         n_got;
        logic [3:0] raw_v;

        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_rep[i] = 0;
        end
        rst = 1'b0; sample_tick = 1'b0; btn_raw = '0; key_ready = 1'b0; ovf_clr = 1'b0;
        clk_n(3);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_held", btn_held, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;
        clk_n(2);

        // Clean press of btn0, then reset mid-debounce of btn1.
        hold_ticks(4'b0001, 4);
        chk("press_held", btn_held, 4'b0001);
        chk("press_valid_lat0", key_valid, 0);
        clk_n(1);
        chk("press_valid_lat1", key_valid, 1);
        chk("press_code", key_code, 0);
        hold_ticks(4'b0011, 2);
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", key_valid, 0);
        chk("arst_held", btn_held, 0);
        chk("arst_code", key_code, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        hold_ticks(4'b0011, 3);
        chk("post_rst_idle", btn_held, 0);
        tick();
        chk("post_rst_held", btn_held, 4'b0011);
        clk_n(1);
        chk("pr_valid_a", key_valid, 1);
        chk("pr_code_a", key_code, 0);
        key_ready = 1'b1;
        clk_n(1);
        chk("pr_gap", key_valid, 0);
        clk_n(1);
        chk("pr_valid_b", key_valid, 1);
        chk("pr_code_b", key_code, 1);
        clk_n(1);
        chk("pr_pulse_end", key_valid, 0);
        key_ready = 1'b0;
        hold_ticks(4'b0000, 3);
        chk("rel_still_held", btn_held, 4'b0011);
        tick();
        chk("rel_done", btn_held, 0);

        // Bounce on btn1.
        hold_ticks(4'b0010, 1);
        hold_ticks(4'b0000, 1);
        hold_ticks(4'b0010, 1);
        chk("bounce_held", btn_held, 0);
        clk_n(2);
        chk("bounce_valid", key_valid, 0);
        hold_ticks(4'b0000, 1);

        // Simultaneous btn3 + btn1 with consumer stalled.
        hold_ticks(4'b1010, 4);
        clk_n(1);
        chk("sim_valid_a", key_valid, 1);
        chk("sim_code_a", key_code, 1);
        clk_n(3);
        chk("sim_stall_valid", key_valid, 1);
        chk("sim_stall_code", key_code, 1);
        key_ready = 1'b1;
        clk_n(1);
        chk("sim_gap", key_valid, 0);
        clk_n(1);
        chk("sim_valid_b", key_valid, 1);
        chk("sim_code_b", key_code, 3);
        clk_n(1);
        chk("sim_drained", key_valid, 0);
        key_ready = 1'b0;
        hold_ticks(4'b0000, 3);
        chk("sim_rel_held", btn_held, 4'b1010);
        tick();
        chk("sim_rel_done", btn_held, 0);

        // Second press of btn2 while its first event is still pending.
        hold_ticks(4'b0100, 4);
        clk_n(1);
        chk("ovf_code", key_code, 2);
        chk("ovf_pre", ovf, 0);
        hold_ticks(4'b0000, 4);
        hold_ticks(4'b0100, 4);
        chk("ovf_set", ovf, 1);
        clk_n(1);
        chk("ovf_valid", key_valid, 1);
        chk("ovf_code2", key_code, 2);
        ovf_clr = 1'b1;
        clk_n(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        key_ready = 1'b1;
        clk_n(1);
        chk("ovf_acc", key_valid, 0);
        clk_n(3);
        chk("ovf_single_evt", key_valid, 0);
        key_ready = 1'b0;
        hold_ticks(4'b0000, 4);

        // Press and accept of btn0 landing on the same edge.
        hold_ticks(4'b0001, 4);
        hold_ticks(4'b0000, 4);
        hold_ticks(4'b0001, 3);
        clk_n(1);
        sample_tick = 1'b1;
        key_ready   = 1'b1;
        clk_n(1);
        sample_tick = 1'b0;
        key_ready   = 1'b0;
        chk("same_valid", key_valid, 0);
        chk("same_ovf", ovf, 0);
        chk("same_held", btn_held, 4'b0001);
        clk_n(1);
        chk("same_repend", key_valid, 1);
        chk("same_code", key_code, 0);
        key_ready = 1'b1;
        clk_n(1);
        chk("same_acc", key_valid, 0);
        key_ready = 1'b0;
        hold_ticks(4'b0000, 4);

        // Long hold of btn0: auto-repeat only when built with it.
        key_ready = 1'b1;
        base = acc_cnt;
        hold_ticks(4'b0001, 4);
        repeat (20) tick();
        clk_n(4);
        chk("hold_events", acc_cnt - base, 1 + (REP_ON ? 20 / TB_REP : 0));
        chk("hold_held", btn_held, 4'b0001);
        hold_ticks(4'b0000, 4);
        chk("hold_rel", btn_held, 0);

        // Randomized run against the model, consumer always ready.
        acc_rd = acc_q.size();
        for (int t = 0; t < 150; t++) begin
            raw_v = btn_raw;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) raw_v[i] = ~raw_v[i];
            end
            btn_raw = raw_v;
            clk_n(1);
            tick();
            exp_q.delete();
            model_tick(raw_v);
            chk("rnd_held", btn_held, m_lvl);
            clk_n(10);
            n_got = acc_q.size() - acc_rd;
            chk("rnd_nevt", n_got, exp_q.size());
            for (int k = 0; k < exp_q.size() && k < n_got; k++) begin
                chk("rnd_code", acc_q[acc_rd + k], exp_q[k]);
            end
            acc_rd = acc_q.size();
        end
        chk("rnd_ovf", ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
